// File: rtl/seq_chk_pkg.sv
// Shared types and defaults for the wrapping-increment sequence checker.
package seq_chk_pkg;

    localparam int unsigned DEF_W        = 2;
    localparam int unsigned DEF_LOCK_CNT = 4;
    localparam int unsigned DEF_LOSS_CNT = 2;
    localparam int unsigned DEF_ERR_W    = 8;

    typedef enum logic [0:0] {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } seq_state_e;

    // Successor symbol; the caller truncates to its own width, which gives the mod 2**W wrap.
    function automatic logic [31:0] next_sym(input logic [31:0] sym);
        return sym + 32'd1;
    endfunction

endpackage

// File: rtl/seq_chk_sat_cnt.sv
// Saturating up-counter with synchronous clear; clear plus increment in one cycle yields 1.
module seq_chk_sat_cnt #(
    parameter int unsigned  W   = 8,
    parameter logic [W-1:0] MAX = '1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt,
    output logic         near_max_c
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = inc ? W'(1) : '0;
        end else if (inc && (cnt_q != MAX)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;
    // One more increment lands exactly on MAX (or stays there).
    assign near_max_c = (cnt_q >= (MAX - W'(1)));

endmodule

// File: rtl/seq_rx_checker.sv
// Receive-side lock/loss checker for a wrapping-increment symbol stream.
// Optional saturating error counter enabled by SEQCHK_ERRCNT_EN.
module seq_rx_checker
    import seq_chk_pkg::*;
#(
    parameter int unsigned W        = DEF_W,
    parameter int unsigned LOCK_CNT = DEF_LOCK_CNT,
    parameter int unsigned LOSS_CNT = DEF_LOSS_CNT,
    parameter int unsigned ERR_W    = DEF_ERR_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [W-1:0]     in_sym,
    input  logic             err_clr,
    output logic             locked,
    output logic             err_pulse,
    output logic [W-1:0]     exp_sym
`ifdef SEQCHK_ERRCNT_EN
    ,
    output logic [ERR_W-1:0] err_cnt
`endif
);

    localparam int unsigned RUN_W  = $clog2(LOCK_CNT + 1);
    localparam int unsigned MISS_W = $clog2(LOSS_CNT + 1);

    seq_state_e   state_q, state_d;
    logic         have_prev_q, have_prev_d;
    logic [W-1:0] prev_q, prev_d;
    logic [W-1:0] exp_sym_q, exp_sym_d;
    logic         locked_q, locked_d;
    logic         err_pulse_q, err_pulse_d;

    logic              run_inc, run_clr, run_near;
    logic              miss_inc, miss_clr, miss_near;
    logic [RUN_W-1:0]  run_cnt;
    logic [MISS_W-1:0] miss_cnt;

    logic [W-1:0] sym_inc_c;
    logic [W-1:0] prev_inc_c;
    logic [W-1:0] exp_inc_c;

    assign sym_inc_c  = W'(next_sym(32'(in_sym)));
    assign prev_inc_c = W'(next_sym(32'(prev_q)));
    assign exp_inc_c  = W'(next_sym(32'(exp_sym_q)));

    seq_chk_sat_cnt #(
        .W   (RUN_W),
        .MAX (RUN_W'(LOCK_CNT))
    ) u_run_cnt (
        .clk        (clk),
        .rst        (rst),
        .clr        (run_clr),
        .inc        (run_inc),
        .cnt        (run_cnt),
        .near_max_c (run_near)
    );

    seq_chk_sat_cnt #(
        .W   (MISS_W),
        .MAX (MISS_W'(LOSS_CNT))
    ) u_miss_cnt (
        .clk        (clk),
        .rst        (rst),
        .clr        (miss_clr),
        .inc        (miss_inc),
        .cnt        (miss_cnt),
        .near_max_c (miss_near)
    );

    logic cnt_unused;
    assign cnt_unused = ^{run_cnt, miss_cnt};

    // Next-state: SEARCH resyncs to the input, LOCKED free-runs exp_sym as a flywheel.
    always_comb begin
        state_d     = state_q;
        have_prev_d = have_prev_q;
        prev_d      = prev_q;
        exp_sym_d   = exp_sym_q;
        locked_d    = locked_q;
        err_pulse_d = 1'b0;
        run_inc     = 1'b0;
        run_clr     = 1'b0;
        miss_inc    = 1'b0;
        miss_clr    = 1'b0;

        if (in_valid) begin
            case (state_q)
                SEARCH: begin
                    prev_d    = in_sym;
                    exp_sym_d = sym_inc_c;
                    if (!have_prev_q) begin
                        have_prev_d = 1'b1;
                    end else if (in_sym == prev_inc_c) begin
                        run_inc = 1'b1;
                        if (run_near) begin
                            state_d  = LOCKED;
                            locked_d = 1'b1;
                            miss_clr = 1'b1;
                        end
                    end else begin
                        run_clr = 1'b1;
                    end
                end
                LOCKED: begin
                    exp_sym_d = exp_inc_c;
                    if (in_sym == exp_sym_q) begin
                        miss_clr = 1'b1;
                    end else begin
                        err_pulse_d = 1'b1;
                        miss_inc    = 1'b1;
                        if (miss_near) begin
                            state_d     = SEARCH;
                            run_clr     = 1'b1;
                            have_prev_d = 1'b0;
                            locked_d    = 1'b0;
                        end
                    end
                end
                default: begin
                    state_d = SEARCH;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= SEARCH;
            have_prev_q <= 1'b0;
            prev_q      <= '0;
            exp_sym_q   <= '0;
            locked_q    <= 1'b0;
            err_pulse_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            have_prev_q <= have_prev_d;
            prev_q      <= prev_d;
            exp_sym_q   <= exp_sym_d;
            locked_q    <= locked_d;
            err_pulse_q <= err_pulse_d;
        end
    end

    assign locked    = locked_q;
    assign err_pulse = err_pulse_q;
    assign exp_sym   = exp_sym_q;

`ifdef SEQCHK_ERRCNT_EN
    logic err_near_unused;

    seq_chk_sat_cnt #(
        .W   (ERR_W),
        .MAX ('1)
    ) u_err_cnt (
        .clk        (clk),
        .rst        (rst),
        .clr        (err_clr),
        .inc        (err_pulse_d),
        .cnt        (err_cnt),
        .near_max_c (err_near_unused)
    );
`else
    logic err_clr_unused;
    assign err_clr_unused = err_clr;
`endif

endmodule
